parity_serial_tx: RTL and testbench

//  Transmit side of the serial even/odd link. Accepts a parallel word over a valid/ready

---
 rtl/parity_link_pkg.sv | 39 +++
 rtl/parity_tx_bit_timer.sv | 58 +++++
 rtl/parity_serial_tx.sv | 175 +++++++++++++++++
 tb/tb_parity_serial_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_link_pkg.sv
// -----------------------------------------------------------------------------
// parity_link_pkg
// Shared definitions for the serial even/odd parity link. The transmitter
// (parity_serial_tx) and the receiving parity FSM both import this package, so
// the frame states, line levels and parity rule are defined in one place.
//
// Contents:
//   tx_state_t   frame-level transmitter states
//   START_LVL    line level of the start bit
//   STOP_LVL     line level of the stop bit
//   IDLE_LVL     line level between frames
//   parity_bit() parity bit for a data word in even or odd mode
// -----------------------------------------------------------------------------
package parity_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    // Widest word the parity helper accepts. Callers zero-extend narrower
    // words; the extra zeros do not change the parity.
    localparam int PARITY_MAX_W = 64;

    // Parity bit such that data plus this bit hold an even count of ones
    // (odd = 0) or an odd count of ones (odd = 1).
    function automatic logic parity_bit(input logic [PARITY_MAX_W-1:0] data,
                                        input logic                    odd);
        parity_bit = (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// parity_tx_bit_timer
// Counts clk cycles inside one serial bit period. While en is high the count
// runs 0 .. BIT_CYCLES-1 and wraps; bit_end flags the last cycle of each
// period. Dropping en (or reset) clears the count so a new frame always
// starts a fresh period.
//
// Ports:
//   clk      in   1       clock, rising edge
//   reset    in   1       synchronous, active-high
//   en       in   1       count while high, clear while low
//   count    out  CNT_W   current cycle within the bit period
//   bit_end  out  1       high in the last cycle of a bit period (en high)
// -----------------------------------------------------------------------------
module parity_tx_bit_timer
    import parity_link_pkg::*;
#(
    parameter  int BIT_CYCLES = 1,
    localparam int CNT_W      = $clog2(BIT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             bit_end
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

    logic [CNT_W-1:0] count_r;
    logic             bit_end_s;

    // End-of-period flag, decoded from the count register.
    always_comb begin
        bit_end_s = 1'b0;
        if (en && (count_r == LAST_CNT)) begin
            bit_end_s = 1'b1;
        end else begin
            bit_end_s = 1'b0;
        end
    end

    // Cycle counter: clears on reset, when disabled and at each period end.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= ZERO_CNT;
        end else if (!en || bit_end_s) begin
            count_r <= ZERO_CNT;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign count   = count_r;
    assign bit_end = bit_end_s;

endmodule

// File: rtl/parity_serial_tx.sv
// -----------------------------------------------------------------------------
// parity_serial_tx
// Transmit side of the serial even/odd link. A parallel word is taken over a
// valid/ready handshake and shifted out on one wire as
//   start(0), DATA_W data bits LSB-first, parity, stop(1)
// with every bit held for BIT_CYCLES clocks. The parity mode is chosen per
// word, so the receiver can classify each frame as even or odd.
//
// The line, busy and frame_done are registered: each register is loaded with
// the value belonging to the state being entered, so the first frame bit is
// on the line in the cycle right after the accepting edge.
//
// Ports:
//   clk         in   1        clock, rising edge
//   reset       in   1        synchronous, active-high; aborts any frame
//   in_data     in   DATA_W   word to send, latched on accept
//   in_odd      in   1        parity mode latched on accept (1 odd, 0 even)
//   in_valid    in   1        producer offers a word
//   in_ready    out  1        high only while IDLE
//   tx          out  1        serial line, idles high
//   busy        out  1        a frame is in progress
//   frame_done  out  1        pulse in the last cycle of the stop bit
// -----------------------------------------------------------------------------
module parity_serial_tx
    import parity_link_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_odd,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W       = $clog2(BIT_CYCLES + 1);
    localparam int IDX_W       = $clog2(DATA_W + 1);
    localparam bit MULTI_CYCLE = (BIT_CYCLES > 1);
    localparam int PENULT_INT  = MULTI_CYCLE ? (BIT_CYCLES - 2) : 0;

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0]  ZERO_IDX   = {IDX_W{1'b0}};
    localparam logic [CNT_W-1:0]  PENULT_CNT = CNT_W'(PENULT_INT);
    localparam logic [DATA_W-1:0] ZERO_DATA  = {DATA_W{1'b0}};

    tx_state_t         state_r;
    logic [DATA_W-1:0] shreg_r;
    logic [IDX_W-1:0]  bit_idx_r;
    logic              par_r;
    logic              tx_r;
    logic              busy_r;
    logic              frame_done_r;

    logic              timer_en_s;
    logic              bit_end_s;
    logic [CNT_W-1:0]  bit_cnt_s;
    logic              stop_last_next_s;

    assign timer_en_s = (state_r != IDLE);

    parity_tx_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .en      (timer_en_s),
        .count   (bit_cnt_s),
        .bit_end (bit_end_s)
    );

    // Decide whether the coming cycle is the final stop-bit cycle, so that
    // frame_done can be registered and still line up with that cycle.
    always_comb begin
        stop_last_next_s = 1'b0;
        if ((state_r == PARITY) && bit_end_s) begin
            // Entering STOP: with one-cycle bits its first cycle is its last.
            stop_last_next_s = !MULTI_CYCLE;
        end else if ((state_r == STOP) && !bit_end_s) begin
            stop_last_next_s = MULTI_CYCLE && (bit_cnt_s == PENULT_CNT);
        end else begin
            stop_last_next_s = 1'b0;
        end
    end

    // Frame FSM with shift register, bit index, parity latch and the
    // registered line, busy and frame_done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            shreg_r      <= ZERO_DATA;
            bit_idx_r    <= ZERO_IDX;
            par_r        <= 1'b0;
            tx_r         <= IDLE_LVL;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= stop_last_next_s;
            case (state_r)
                IDLE: begin
                    // in_ready is high in IDLE, so in_valid alone accepts.
                    if (in_valid) begin
                        state_r   <= START;
                        shreg_r   <= in_data;
                        par_r     <= parity_bit(PARITY_MAX_W'(in_data), in_odd);
                        bit_idx_r <= ZERO_IDX;
                        tx_r      <= START_LVL;
                        busy_r    <= 1'b1;
                    end else begin
                        tx_r   <= IDLE_LVL;
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    // shreg_r[0] always holds the next data bit to send.
                    if (bit_end_s) begin
                        state_r <= DATA;
                        tx_r    <= shreg_r[0];
                        shreg_r <= shreg_r >> 1'b1;
                    end else begin
                        tx_r <= START_LVL;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        if (bit_idx_r == LAST_IDX) begin
                            state_r   <= PARITY;
                            bit_idx_r <= ZERO_IDX;
                            tx_r      <= par_r;
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                            tx_r      <= shreg_r[0];
                            shreg_r   <= shreg_r >> 1'b1;
                        end
                    end else begin
                        bit_idx_r <= bit_idx_r;
                    end
                end
                PARITY: begin
                    if (bit_end_s) begin
                        state_r <= STOP;
                        tx_r    <= STOP_LVL;
                    end else begin
                        tx_r <= par_r;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        state_r <= IDLE;
                        tx_r    <= IDLE_LVL;
                        busy_r  <= 1'b0;
                    end else begin
                        tx_r <= STOP_LVL;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bit_idx_r <= ZERO_IDX;
                    tx_r      <= IDLE_LVL;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = (state_r == IDLE);
    assign tx         = tx_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_parity_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_parity_serial_tx
// Two instances share clk/reset: index 0 uses one-cycle bits, index 1 uses
// four-cycle bits. Every accepted word pushes its expected line sequence
// (start, data LSB-first, parity, stop, each bit repeated BIT_CYCLES times)
// onto a per-instance queue; a negedge monitor pops one entry per busy cycle
// and checks tx, frame_done and in_ready, and checks the idle levels otherwise.
// -----------------------------------------------------------------------------
module tb_parity_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data    [2];
    logic       in_odd     [2];
    logic       in_valid   [2];
    logic       in_ready   [2];
    logic       tx         [2];
    logic       busy       [2];
    logic       frame_done [2];

    typedef struct {
        logic tx;
        logic last;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       odd;
        logic       exp_par;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_on = 1'b0;
    int   fd_cyc [2];

    parity_serial_tx #(.DATA_W(8), .BIT_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data[0]), .in_odd(in_odd[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .tx(tx[0]),
        .busy(busy[0]), .frame_done(frame_done[0])
    );

    parity_serial_tx #(.DATA_W(8), .BIT_CYCLES(4)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data[1]), .in_odd(in_odd[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .tx(tx[1]),
        .busy(busy[1]), .frame_done(frame_done[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Build the expected line sequence of one frame.
    task automatic push_frame(input int d, input logic [7:0] data, input logic par);
        logic [10:0] bits;
        int          bc;
        exp_t        e;
        bc = (d == 0) ? 1 : 4;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        bits[9]  = par;
        bits[10] = 1'b1;
        for (int b = 0; b < 11; b++) begin
            for (int r = 0; r < bc; r++) begin
                e.tx   = bits[b];
                e.last = (b == 10) && (r == bc - 1);
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        if (frame_done[d] === 1'b1) fd_cyc[d] = cyc;
        if (busy[d] === 1'b1) begin
            if (qsize(d) == 0) begin
                checks++;
                errors++;
                $display("FAIL busy_unexpected dut%0d: busy=1 with no frame pending (cycle %0d)", d, cyc);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("tx dut%0d", d), 32'(tx[d]), 32'(e.tx));
                chk($sformatf("frame_done dut%0d", d), 32'(frame_done[d]), 32'(e.last));
                chk($sformatf("in_ready_busy dut%0d", d), 32'(in_ready[d]), 32'd0);
            end
        end else begin
            chk($sformatf("idle_tx dut%0d", d), 32'(tx[d]), 32'd1);
            chk($sformatf("idle_frame_done dut%0d", d), 32'(frame_done[d]), 32'd0);
            chk($sformatf("idle_in_ready dut%0d", d), 32'(in_ready[d]), 32'd1);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon(0);
            mon(1);
        end
    end

    // Offer a word, wait (bounded) for acceptance, push its expected frame.
    // Returns at #1 after the accepting edge; acc is the cycle number then.
    task automatic send(input int d, input logic [7:0] data, input logic odd,
                        input logic par, input bit keep, output int acc);
        int n;
        n = 0;
        fd_cyc[d]   = -1;
        in_data[d]  = data;
        in_odd[d]   = odd;
        in_valid[d] = 1'b1;
        while (in_ready[d] !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("accept_timeout dut%0d", d), 32'(n < 300), 32'd1);
        push_frame(d, data, par);
        @(posedge clk);
        #1;
        acc = cyc;
        if (!keep) in_valid[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain_timeout dut%0d", d), 32'(n < 1000), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [9];
        int   acc;
        int   acc2;

        vecs[0] = '{8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1};
        vecs[2] = '{8'h07, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 1'b1, 1'b0};
        vecs[7] = '{8'h3C, 1'b1, 1'b1};
        vecs[8] = '{8'h80, 1'b0, 1'b1};

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_data[d]  = 8'h00;
            in_odd[d]   = 1'b0;
            in_valid[d] = 1'b0;
            fd_cyc[d]   = -1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_tx dut%0d", d), 32'(tx[d]), 32'd1);
            chk($sformatf("reset_busy dut%0d", d), 32'(busy[d]), 32'd0);
            chk($sformatf("reset_frame_done dut%0d", d), 32'(frame_done[d]), 32'd0);
            chk($sformatf("reset_in_ready dut%0d", d), 32'(in_ready[d]), 32'd1);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_on = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Parity/data vectors on the one-cycle-bit instance.
        for (int i = 0; i < 9; i++) begin
            send(0, vecs[i].data, vecs[i].odd, vecs[i].exp_par, 1'b0, acc);
            wait_done(0);
            chk($sformatf("frame_len vec%0d", i), 32'(fd_cyc[0] - acc), 32'd10);
        end

        // Four-cycle bits: 44-cycle frame.
        send(1, 8'h81, 1'b0, 1'b0, 1'b0, acc);
        wait_done(1);
        chk("frame_len bc4", 32'(fd_cyc[1] - acc), 32'd43);

        // in_valid held high across two words: one idle cycle between frames.
        send(0, 8'h3C, 1'b0, 1'b0, 1'b1, acc);
        send(0, 8'hC3, 1'b0, 1'b0, 1'b0, acc2);
        chk("b2b_accept_gap", 32'(acc2 - acc), 32'd12);
        wait_done(0);
        chk("b2b_frame_len", 32'(fd_cyc[0] - acc2), 32'd10);

        // Reset during DATA bit 3 aborts the frame.
        send(0, 8'hE6, 1'b0, 1'b1, 1'b0, acc);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q0.delete();
        @(negedge clk);
        #1;
        chk("abort_tx", 32'(tx[0]), 32'd1);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
        chk("abort_frame_done", 32'(frame_done[0]), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("abort_no_done_pulse", 32'(fd_cyc[0]), 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        send(0, 8'hA5, 1'b1, 1'b1, 1'b0, acc);
        wait_done(0);
        chk("post_abort_frame_len", 32'(fd_cyc[0] - acc), 32'd10);

        // Inputs changing every cycle after accept must not disturb the frame.
        send(0, 8'h5A, 1'b0, 1'b0, 1'b0, acc);
        in_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data[0] = 8'($urandom);
            in_odd[0]  = ~in_odd[0];
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0;
        wait_done(0);
        chk("toggle_frame_len", 32'(fd_cyc[0] - acc), 32'd10);

        // Idle with in_valid low: the monitor checks tx stays high.
        repeat (6) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
